// File: rtl/dual_issue_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : issue_pkg
// Description : Shared constants for the dual-issue scheduler slice.
//               This package provides the default register-file geometry,
//               the load latency, the scoreboard counter width and the
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package issue_pkg;

  // Default register-file geometry and load latency
  localparam int DEF_RW       = 3;
  localparam int DEF_NREG     = 8;
  localparam int DEF_LOAD_LAT = 2;

  // Width of one scoreboard counter.
  // It must be able to hold the value LOAD_LAT.
  localparam int CNT_W = $clog2(DEF_LOAD_LAT + 1);

  // Issue FSM encoding
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_HOLD2 = 1'b1;

endpackage : issue_pkg
`default_nettype wire

// File: rtl/dual_issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface   : dual_issue_scheduler_if
// Description : Carries the ID-stage signals between the decoder and the
//               dual-issue scheduler.
//               - master : the ID stage. It drives the decoded pair and the
//                          flush input, and it receives the issue decision.
//               - slave  : the scheduler itself.
//               Signals:
//                 id_valid, i1_*, i2_*, ex_flush -> scheduler
//                 issue1, issue2, id_ready, stall, hold2 <- scheduler
// Revision    : 1.0 - initial release
// ============================================================================
interface dual_issue_scheduler_if
  import issue_pkg::*;
#(
  parameter int RW = DEF_RW
);
  logic          id_valid;
  logic [RW-1:0] i1_rd, i1_rs, i1_rt;
  logic          i1_regwrite, i1_is_load, i1_uses_rt;
  logic [RW-1:0] i2_rd, i2_rs, i2_rt;
  logic          i2_regwrite, i2_is_load, i2_uses_rt;
  logic          ex_flush;
  logic          issue1, issue2, id_ready, stall, hold2;

  modport master (
    output id_valid,
    output i1_rd, i1_rs, i1_rt, i1_regwrite, i1_is_load, i1_uses_rt,
    output i2_rd, i2_rs, i2_rt, i2_regwrite, i2_is_load, i2_uses_rt,
    output ex_flush,
    input  issue1, issue2, id_ready, stall, hold2
  );

  modport slave (
    input  id_valid,
    input  i1_rd, i1_rs, i1_rt, i1_regwrite, i1_is_load, i1_uses_rt,
    input  i2_rd, i2_rs, i2_rt, i2_regwrite, i2_is_load, i2_uses_rt,
    input  ex_flush,
    output issue1, issue2, id_ready, stall, hold2
  );
endinterface : dual_issue_scheduler_if
`default_nettype wire

// File: rtl/dual_issue_scheduler_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard
// Description : Per-register countdown scoreboard for in-flight loads.
//               A set writes LOAD_LAT into cnt[rd]. Otherwise, every
//               counter decrements and saturates at zero. A set takes
//               priority over the decrement. Register 0 is never marked
//               busy.
// Ports       : clk, rst_n            clock, async active-low reset
//               set1_en/set1_rd       slot 1 load marks its destination
//               set2_en/set2_rd       slot 2 load marks its destination
//               q_src[3:0]            four source register queries
//               q_busy[3:0]           busy flag per query
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int RW       = DEF_RW,
  parameter int NREG     = DEF_NREG,
  parameter int LOAD_LAT = DEF_LOAD_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set1_en,
  input  logic [RW-1:0]       set1_rd,
  input  logic                set2_en,
  input  logic [RW-1:0]       set2_rd,
  input  logic [3:0][RW-1:0]  q_src,
  output logic [3:0]          q_busy
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  logic [CW-1:0] cnt [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if ((set1_en && set1_rd == RW'(i)) || (set2_en && set2_rd == RW'(i)))
          cnt[i] <= CW'(LOAD_LAT);
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++)
      q_busy[k] = (q_src[k] != '0) && (cnt[q_src[k]] != '0);
  end

endmodule : issue_scoreboard
`default_nettype wire

// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_scheduler
// Description : Issue controller between ID and ID/EX for a dual-issue
//               pipeline. Each cycle it decides one of three outcomes:
//               issue both slots, split (issue slot 1 now and slot 2 later
//               from HOLD2), or stall. The decision uses a load scoreboard
//               and intra-pair conflict detection.
// Ports       : clk, rst_n            clock, async active-low reset
//               bus (slave modport)   ID pair in, issue decision out
//               stall_cnt, split_cnt  performance counters; these exist only
//                                     with ISSUE_PERF_CNT_EN
// Options     : `define ISSUE_PERF_CNT_EN to add the saturating 16-bit
//               counters. stall_cnt counts stall cycles. split_cnt counts
//               RUN->HOLD2 transitions.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_scheduler
  import issue_pkg::*;
#(
  parameter int RW       = DEF_RW,
  parameter int NREG     = DEF_NREG,
  parameter int LOAD_LAT = DEF_LOAD_LAT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dual_issue_scheduler_if.slave  bus
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]            stall_cnt,
  output logic [15:0]            split_cnt
`endif
);

  logic [0:0] state, state_nxt;
  logic       issue1, issue2, id_ready, stall;
  logic [3:0] q_busy;
  logic       blk1, blk2;
  logic       raw, waw, two_loads, conflict;

  issue_scoreboard #(
    .RW       (RW),
    .NREG     (NREG),
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set1_en (issue1 && bus.i1_is_load && bus.i1_regwrite && bus.i1_rd != '0),
    .set1_rd (bus.i1_rd),
    .set2_en (issue2 && bus.i2_is_load && bus.i2_regwrite && bus.i2_rd != '0),
    .set2_rd (bus.i2_rd),
    .q_src   ({bus.i2_rt, bus.i2_rs, bus.i1_rt, bus.i1_rs}),
    .q_busy  (q_busy)
  );

  // A source is counted only when the slot actually reads it.
  // rs is always read. rt is read only when uses_rt is set.
  assign blk1 = q_busy[0] || (bus.i1_uses_rt && q_busy[1]);
  assign blk2 = q_busy[2] || (bus.i2_uses_rt && q_busy[3]);

  // Forwarding cannot pass a value between slots of the same pair.
  // The memory unit has only one port, so two loads cannot issue together.
  assign raw = bus.i1_regwrite && (bus.i1_rd != '0) &&
               ((bus.i1_rd == bus.i2_rs) ||
                (bus.i2_uses_rt && (bus.i1_rd == bus.i2_rt)));
  assign waw = bus.i1_regwrite && bus.i2_regwrite &&
               (bus.i1_rd == bus.i2_rd) && (bus.i1_rd != '0);
  assign two_loads = bus.i1_is_load && bus.i2_is_load;
  assign conflict  = raw || waw || two_loads;

  always_comb begin
    issue1    = 1'b0;
    issue2    = 1'b0;
    id_ready  = 1'b0;
    stall     = 1'b0;
    state_nxt = state;
    if (!rst_n) begin
      state_nxt = ST_RUN;
    end else if (bus.ex_flush) begin
      state_nxt = ST_RUN;
    end else if (state == ST_RUN) begin
      if (bus.id_valid) begin
        if (blk1) begin
          stall = 1'b1;
        end else if (conflict || blk2) begin
          issue1    = 1'b1;
          state_nxt = ST_HOLD2;
        end else begin
          issue1   = 1'b1;
          issue2   = 1'b1;
          id_ready = 1'b1;
        end
      end
    end else begin
      // The pair is held stable in ID. Only slot 2 is still pending.
      if (blk2) begin
        stall = 1'b1;
      end else begin
        issue2    = 1'b1;
        id_ready  = 1'b1;
        state_nxt = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  assign bus.issue1   = issue1;
  assign bus.issue2   = issue2;
  assign bus.id_ready = id_ready;
  assign bus.stall    = stall;
  assign bus.hold2    = (state == ST_HOLD2);

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      split_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (state == ST_RUN && state_nxt == ST_HOLD2 && split_cnt != 16'hFFFF)
        split_cnt <= split_cnt + 16'd1;
    end
  end
`endif

endmodule : dual_issue_scheduler
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_issue_scheduler
// Description : Directed self-checking bench for dual_issue_scheduler.
//               Inputs are driven on the falling clock edge. Outputs are
//               sampled 1 ns later, well away from the rising edge.
//               Scoreboard counters are observed hierarchically.
// Options     : honours ISSUE_PERF_CNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_issue_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dual_issue_scheduler_if bus ();

`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] stall_cnt, split_cnt;
`endif

  dual_issue_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .split_cnt (split_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic e1, input logic e2,
                            input logic er, input logic es, input logic eh);
    check_val({tag, ".issue1"},   32'(bus.issue1),   32'(e1));
    check_val({tag, ".issue2"},   32'(bus.issue2),   32'(e2));
    check_val({tag, ".id_ready"}, 32'(bus.id_ready), 32'(er));
    check_val({tag, ".stall"},    32'(bus.stall),    32'(es));
    check_val({tag, ".hold2"},    32'(bus.hold2),    32'(eh));
  endtask

  task automatic set_pair(input logic [2:0] rd1, input logic [2:0] rs1, input logic [2:0] rt1,
                          input logic rw1, input logic ld1, input logic ut1,
                          input logic [2:0] rd2, input logic [2:0] rs2, input logic [2:0] rt2,
                          input logic rw2, input logic ld2, input logic ut2);
    bus.id_valid    = 1'b1;
    bus.i1_rd = rd1; bus.i1_rs = rs1; bus.i1_rt = rt1;
    bus.i1_regwrite = rw1; bus.i1_is_load = ld1; bus.i1_uses_rt = ut1;
    bus.i2_rd = rd2; bus.i2_rs = rs2; bus.i2_rt = rt2;
    bus.i2_regwrite = rw2; bus.i2_is_load = ld2; bus.i2_uses_rt = ut2;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.ex_flush = 1'b0;
    set_pair(3'd1, 3'd2, 3'd3, 1, 0, 1,  3'd4, 3'd5, 3'd6, 1, 0, 1);

    // Reset: every output is low, even though a valid pair is present.
    @(negedge clk); #1;
    expect_out("reset", 0, 0, 0, 0, 0);

    // Independent pair: both slots issue in the same cycle.
    @(negedge clk); rst_n = 1'b1; #1;
    expect_out("indep", 1, 1, 1, 0, 0);
    @(negedge clk); idle(); #1;
    expect_out("indep_after", 0, 0, 0, 0, 0);

    // RAW inside the pair: split, then slot 2 issues from HOLD2.
    @(negedge clk); set_pair(3'd1, 3'd2, 3'd3, 1, 0, 1,  3'd4, 3'd1, 3'd5, 1, 0, 1); #1;
    expect_out("raw_c0", 1, 0, 0, 0, 0);
    @(negedge clk); #1;
    expect_out("raw_c1", 0, 1, 1, 0, 1);
    @(negedge clk); idle(); #1;
    expect_out("raw_back", 0, 0, 0, 0, 0);

    // Load-use: ld r2 issues. A slot-1 reader of r2 then waits until cnt[2] drains.
    @(negedge clk); set_pair(3'd2, 3'd0, 3'd0, 1, 1, 0,  3'd4, 3'd5, 3'd6, 1, 0, 1); #1;
    expect_out("ld_issue", 1, 1, 1, 0, 0);
    @(negedge clk); set_pair(3'd3, 3'd2, 3'd0, 1, 0, 0,  3'd5, 3'd6, 3'd7, 1, 0, 1); #1;
    check_val("ld_cnt2_a", 32'(dut.u_sb.cnt[2]), 32'd2);
    expect_out("lu_stall_a", 0, 0, 0, 1, 0);
    @(negedge clk); #1;
    check_val("ld_cnt2_b", 32'(dut.u_sb.cnt[2]), 32'd1);
    expect_out("lu_stall_b", 0, 0, 0, 1, 0);
    @(negedge clk); #1;
    expect_out("lu_issue", 1, 1, 1, 0, 0);

    // Two loads: split. The second load issues from HOLD2.
    @(negedge clk); set_pair(3'd1, 3'd2, 3'd0, 1, 1, 0,  3'd3, 3'd4, 3'd0, 1, 1, 0); #1;
    expect_out("2ld_c0", 1, 0, 0, 0, 0);
    @(negedge clk); #1;
    check_val("2ld_cnt1", 32'(dut.u_sb.cnt[1]), 32'd2);
    expect_out("2ld_c1", 0, 1, 1, 0, 1);
    @(negedge clk); idle(); #1;
    check_val("2ld_cnt3", 32'(dut.u_sb.cnt[3]), 32'd2);
    check_val("2ld_cnt1_dec", 32'(dut.u_sb.cnt[1]), 32'd1);
    expect_out("2ld_back", 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);

    // Flush while in HOLD2 with slot 2 blocked on r2.
    @(negedge clk); set_pair(3'd2, 3'd0, 3'd0, 1, 1, 0,  3'd4, 3'd5, 3'd0, 1, 0, 0); #1;
    expect_out("fl_ld", 1, 1, 1, 0, 0);
    @(negedge clk); set_pair(3'd6, 3'd7, 3'd0, 1, 0, 0,  3'd3, 3'd2, 3'd0, 1, 0, 0); #1;
    expect_out("fl_split", 1, 0, 0, 0, 0);
    @(negedge clk); bus.ex_flush = 1'b1; #1;
    check_val("fl_cnt2", 32'(dut.u_sb.cnt[2]), 32'd1);
    check_val("fl.issue1",   32'(bus.issue1),   32'd0);
    check_val("fl.issue2",   32'(bus.issue2),   32'd0);
    check_val("fl.id_ready", 32'(bus.id_ready), 32'd0);
    check_val("fl.stall",    32'(bus.stall),    32'd0);
    @(negedge clk); bus.ex_flush = 1'b0; idle(); #1;
    check_val("fl_cnt2_zero", 32'(dut.u_sb.cnt[2]), 32'd0);
    expect_out("fl_run", 0, 0, 0, 0, 0);

    // Reset in the middle of HOLD2 while cnt[5] is pending.
    @(negedge clk); set_pair(3'd5, 3'd0, 3'd0, 1, 1, 0,  3'd4, 3'd5, 3'd6, 1, 0, 1); #1;
    expect_out("rs_split", 1, 0, 0, 0, 0);
    @(negedge clk); #1;
    check_val("rs_cnt5", 32'(dut.u_sb.cnt[5]), 32'd2);
    expect_out("rs_hold", 0, 0, 0, 1, 1);
    rst_n = 1'b0; #1;
    expect_out("rs_low", 0, 0, 0, 0, 0);
    check_val("rs_cnt5_clr", 32'(dut.u_sb.cnt[5]), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    set_pair(3'd1, 3'd5, 3'd0, 1, 0, 0,  3'd2, 3'd3, 3'd4, 1, 0, 1); #1;
    expect_out("rs_after", 1, 1, 1, 0, 0);

`ifdef ISSUE_PERF_CNT_EN
    // One stall followed by one split. Both counters restarted at the reset above.
    @(negedge clk); set_pair(3'd3, 3'd0, 3'd0, 1, 1, 0,  3'd4, 3'd5, 3'd0, 1, 0, 0); #1;
    @(negedge clk); set_pair(3'd6, 3'd3, 3'd0, 1, 0, 0,  3'd7, 3'd1, 3'd0, 1, 0, 0); #1;
    expect_out("pc_stall", 0, 0, 0, 1, 0);
    @(negedge clk); set_pair(3'd6, 3'd1, 3'd0, 1, 0, 0,  3'd7, 3'd6, 3'd0, 1, 0, 0); #1;
    expect_out("pc_split", 1, 0, 0, 0, 0);
    @(negedge clk); idle(); #1;
    @(negedge clk); #1;
    check_val("pc_stall_cnt", 32'(stall_cnt), 32'd1);
    check_val("pc_split_cnt", 32'(split_cnt), 32'd1);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dual_issue_scheduler
`default_nettype wire
